// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MEM-stage FSM states and data-memory wait defaults.
package cpu_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDone
   } mem_state_e;

   localparam int unsigned MaxWaitDefault = 15;
   localparam int unsigned WaitCntW       = 16;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts enabled cycles since the last clear; flags the cycle that is the limit-th one.
module mem_wait_timer
   import cpu_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                clear_i,
   input  logic                enable_i,
   input  logic [WaitCntW-1:0] limit_i,
   output logic                expired_o
);

   logic [WaitCntW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + WaitCntW'(1);
      end
   end

   // count_q holds the number of earlier enabled cycles, so this is the limit-th one
   assign expired_o = enable_i && (count_q == limit_i - WaitCntW'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: drives the data-memory bus, stalls upstream until ack or timeout.
// Optional build macro MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned accesses with bus_err.
module mem_access
   import cpu_pkg::*;
#(
   parameter int unsigned MAX_WAIT = MaxWaitDefault
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [31:0] alu_out_in,
   input  logic [31:0] wdata_in,
   input  logic [4:0]  rfile_wn_in,
   input  logic        MemtoReg_in,
   input  logic        RegWrite_in,
   output logic [31:0] alu_out_out,
   output logic [31:0] rd_out,
   output logic [4:0]  rfile_wn_out,
   output logic        MemtoReg_out,
   output logic        RegWrite_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_out,
   output logic        bus_err
);

   mem_state_e  state_q, state_d;
   logic        req_q, req_d, we_q, we_d, bus_err_q, bus_err_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d;
   logic        access, misalign, timer_clear, timer_en, timer_expired;
   logic [31:0] issue_addr;

   assign access = mem_read_in | mem_write_in;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
   assign misalign   = (alu_out_in[1:0] != 2'b00);
   assign issue_addr = alu_out_in;
`else
   assign misalign   = 1'b0;
   assign issue_addr = {alu_out_in[31:2], 2'b00};
`endif

   mem_wait_timer u_wait_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (timer_clear),
      .enable_i  (timer_en),
      .limit_i   (WaitCntW'(MAX_WAIT)),
      .expired_o (timer_expired)
   );

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      bus_err_d   = 1'b0;
      timer_clear = 1'b0;
      timer_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (access) begin
               timer_clear = 1'b1;
               if (misalign) begin
                  state_d   = StDone;
                  bus_err_d = 1'b1;
                  if (!mem_write_in) rd_d = '0;
               end else begin
                  state_d = StWait;
                  req_d   = 1'b1;
                  we_d    = mem_write_in;  // read+write together counts as a store
                  addr_d  = issue_addr;
                  wdata_d = wdata_in;
               end
            end
         end
         StWait: begin
            timer_en = 1'b1;
            // ack takes priority over a timeout landing in the same cycle
            if (dmem_ack) begin
               if (!we_q) rd_d = dmem_rdata;
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = StDone;
            end else if (timer_expired) begin
               bus_err_d = 1'b1;
               rd_d      = '0;
               req_d     = 1'b0;
               we_d      = 1'b0;
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_q      <= rd_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign stall_out    = ((state_q == StIdle) && access) || (state_q == StWait);
   assign RegWrite_out = RegWrite_in & ~stall_out;
   assign alu_out_out  = alu_out_in;
   assign rfile_wn_out = rfile_wn_in;
   assign MemtoReg_out = MemtoReg_in;
   assign rd_out       = rd_q;
   assign bus_err      = bus_err_q;
   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (default MAX_WAIT of 15).
module tb_mem_access;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_in, mem_write_in, MemtoReg_in, RegWrite_in;
   logic [31:0] alu_out_in, wdata_in, alu_out_out, rd_out, dmem_addr, dmem_wdata, dmem_rdata;
   logic [4:0]  rfile_wn_in, rfile_wn_out;
   logic        MemtoReg_out, RegWrite_out, dmem_req, dmem_we, dmem_ack, stall_out, bus_err;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   always #5 clk = ~clk;

   mem_access u_dut (
      .clk          (clk),
      .reset        (reset),
      .mem_read_in  (mem_read_in),
      .mem_write_in (mem_write_in),
      .alu_out_in   (alu_out_in),
      .wdata_in     (wdata_in),
      .rfile_wn_in  (rfile_wn_in),
      .MemtoReg_in  (MemtoReg_in),
      .RegWrite_in  (RegWrite_in),
      .alu_out_out  (alu_out_out),
      .rd_out       (rd_out),
      .rfile_wn_out (rfile_wn_out),
      .MemtoReg_out (MemtoReg_out),
      .RegWrite_out (RegWrite_out),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_ack     (dmem_ack),
      .dmem_rdata   (dmem_rdata),
      .stall_out    (stall_out),
      .bus_err      (bus_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1-2 time units after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic no_access();
      mem_read_in  = 1'b0;
      mem_write_in = 1'b0;
      dmem_ack     = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      no_access();
      alu_out_in = '0; wdata_in = '0; dmem_rdata = '0;
      rfile_wn_in = 5'd0; MemtoReg_in = 1'b0; RegWrite_in = 1'b0;
      tick(); tick();
      reset = 1'b0;
      settle();
      check_eq("rst_req", 32'(dmem_req), 32'd0);
      check_eq("rst_addr", dmem_addr, 32'd0);
      check_eq("rst_rd", rd_out, 32'd0);
      check_eq("rst_err", 32'(bus_err), 32'd0);
      check_eq("rst_stall", 32'(stall_out), 32'd0);

      // Load 0x100, ack on first WAIT cycle
      tick();
      mem_read_in = 1'b1; alu_out_in = 32'h100; RegWrite_in = 1'b1;
      MemtoReg_in = 1'b1; rfile_wn_in = 5'd5;
      settle();
      check_eq("ld_stall_idle", 32'(stall_out), 32'd1);
      check_eq("ld_regwr_idle", 32'(RegWrite_out), 32'd0);
      check_eq("ld_alu_pass", alu_out_out, 32'h100);
      check_eq("ld_wn_pass", 32'(rfile_wn_out), 32'd5);
      check_eq("ld_m2r_pass", 32'(MemtoReg_out), 32'd1);
      tick();
      dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
      settle();
      check_eq("ld_req", 32'(dmem_req), 32'd1);
      check_eq("ld_addr", dmem_addr, 32'h100);
      check_eq("ld_we", 32'(dmem_we), 32'd0);
      check_eq("ld_stall_wait", 32'(stall_out), 32'd1);
      check_eq("ld_regwr_wait", 32'(RegWrite_out), 32'd0);
      tick();
      dmem_ack = 1'b0;
      settle();
      check_eq("ld_rd_done", rd_out, 32'hDEADBEEF);
      check_eq("ld_stall_done", 32'(stall_out), 32'd0);
      check_eq("ld_req_done", 32'(dmem_req), 32'd0);
      check_eq("ld_regwr_done", 32'(RegWrite_out), 32'd1);
      check_eq("ld_err_done", 32'(bus_err), 32'd0);
      tick();
      no_access();
      settle();
      check_eq("idle_after_ld", 32'(stall_out), 32'd0);

      // Store (read+write both set) to 0x200, ack on 4th WAIT cycle
      mem_read_in = 1'b1; mem_write_in = 1'b1;
      alu_out_in = 32'h200; wdata_in = 32'h12345678;
      tick();
      alu_out_in = 32'hFFFF; wdata_in = 32'h0;
      dmem_rdata = 32'hBAD0BAD0;
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) dmem_ack = 1'b1;
         settle();
         check_eq($sformatf("st_req_%0d", i), 32'(dmem_req), 32'd1);
         check_eq($sformatf("st_we_%0d", i), 32'(dmem_we), 32'd1);
         check_eq($sformatf("st_addr_%0d", i), dmem_addr, 32'h200);
         check_eq($sformatf("st_wdata_%0d", i), dmem_wdata, 32'h12345678);
         tick();
      end
      dmem_ack = 1'b0;
      settle();
      check_eq("st_rd_kept", rd_out, 32'hDEADBEEF);
      check_eq("st_stall_done", 32'(stall_out), 32'd0);
      tick();
      no_access();

      // Load with no ack: timeout after 15 WAIT cycles
      mem_read_in = 1'b1; alu_out_in = 32'h300;
      tick();
      for (int i = 1; i <= 15; i++) begin
         settle();
         check_eq($sformatf("to_stall_%0d", i), 32'(stall_out), 32'd1);
         check_eq($sformatf("to_err_%0d", i), 32'(bus_err), 32'd0);
         tick();
      end
      settle();
      check_eq("to_err_pulse", 32'(bus_err), 32'd1);
      check_eq("to_rd_zero", rd_out, 32'd0);
      check_eq("to_stall_rel", 32'(stall_out), 32'd0);
      check_eq("to_req_drop", 32'(dmem_req), 32'd0);
      tick();
      no_access();
      settle();
      check_eq("to_err_once", 32'(bus_err), 32'd0);

      // Ack on the 15th WAIT cycle wins over the timeout
      mem_read_in = 1'b1; alu_out_in = 32'h400;
      tick();
      for (int i = 1; i <= 15; i++) begin
         if (i == 15) begin
            dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
         end
         tick();
      end
      dmem_ack = 1'b0;
      settle();
      check_eq("coin_rd", rd_out, 32'hCAFEF00D);
      check_eq("coin_err", 32'(bus_err), 32'd0);
      tick();
      no_access();

      // Misaligned load to 0x102
      mem_read_in = 1'b1; alu_out_in = 32'h102;
      tick();
      settle();
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      check_eq("mis_req", 32'(dmem_req), 32'd0);
      check_eq("mis_err", 32'(bus_err), 32'd1);
      check_eq("mis_rd", rd_out, 32'd0);
      check_eq("mis_stall", 32'(stall_out), 32'd0);
`else
      check_eq("mis_req", 32'(dmem_req), 32'd1);
      check_eq("mis_addr", dmem_addr, 32'h100);
      dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
      tick();
      dmem_ack = 1'b0;
      settle();
      check_eq("mis_rd", rd_out, 32'h55AA55AA);
      check_eq("mis_err", 32'(bus_err), 32'd0);
`endif
      tick();
      no_access();

      // Reset in the 3rd WAIT cycle abandons the access
      mem_read_in = 1'b1; alu_out_in = 32'h500;
      tick(); tick(); tick();
      settle();
      check_eq("rw_req_wait3", 32'(dmem_req), 32'd1);
      reset = 1'b1; mem_read_in = 1'b0;
      tick();
      reset = 1'b0;
      settle();
      check_eq("rw_req_after", 32'(dmem_req), 32'd0);
      check_eq("rw_stall_after", 32'(stall_out), 32'd0);
      dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
      tick();
      dmem_ack = 1'b0;
      settle();
      check_eq("rw_late_ack_rd", rd_out, 32'd0);
      check_eq("rw_late_ack_req", 32'(dmem_req), 32'd0);
      check_eq("rw_late_ack_err", 32'(bus_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter MAX_WAIT, default 15, SHALL be the number of WAIT cycles without dmem_ack before a timeout.
REQ-002 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Inputs from the EX/MEM register SHALL be:
- mem_read_in  input  1  load
- mem_write_in  input  1  store
- alu_out_in  input  32  effective address / ALU result
- wdata_in  input  32  store data
- rfile_wn_in  input  5  destination register
- MemtoReg_in  input  1  writeback select
- RegWrite_in  input  1  writeback enable
REQ-005 Outputs to the MEM/WB register SHALL be:
- alu_out_out  output  32
- rd_out  output  32  load data
- rfile_wn_out  output  5
- MemtoReg_out  output  1
- RegWrite_out  output  1
REQ-006 Data memory bus SHALL be:
- dmem_req  output  1
- dmem_we  output  1
- dmem_addr  output  32
- dmem_wdata  output  32
- dmem_ack  input  1
- dmem_rdata  input  32
REQ-007 Pipeline and error signals SHALL be:
- stall_out  output  1  freeze upstream stages
- bus_err  output  1  one-cycle timeout pulse

Function
REQ-008 access SHALL be defined as mem_read_in | mem_write_in; if both are set, it SHALL be treated as a store.
REQ-009 The FSM SHALL have states IDLE, WAIT, DONE.
REQ-010 In IDLE with access=1, the block SHALL latch the address, wdata and we, clear the wait counter, and go to WAIT.
REQ-011 In IDLE with access=0, the FSM SHALL stay in IDLE.
REQ-012 dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL be registered, driven from the latched values, and held stable throughout WAIT; dmem_req SHALL be 0 in IDLE and DONE.
REQ-013 In WAIT with dmem_ack=1, the block SHALL capture dmem_rdata into rd_out (loads only; stores leave rd_out unchanged) and go to DONE.
REQ-014 In WAIT without ack, the counter SHALL increment; when it reaches MAX_WAIT, bus_err SHALL pulse for 1 cycle, rd_out SHALL become 0, and the FSM SHALL go to DONE.
REQ-015 If ack arrives in the same cycle as the timeout, ack SHALL win: no bus_err, data captured.
REQ-016 DONE SHALL last exactly 1 cycle, then go to IDLE; the same instruction SHALL NOT be re-issued.
REQ-017 dmem_ack in IDLE or DONE SHALL be ignored.
REQ-018 stall_out SHALL be combinational: (IDLE & access) | WAIT; stall_out SHALL be 0 in DONE.
REQ-019 Minimum memory latency SHALL be: ack in the first WAIT cycle gives 2 stall cycles.
REQ-020 alu_out_out, rfile_wn_out and MemtoReg_out SHALL be combinational passthroughs.
REQ-021 RegWrite_out SHALL be RegWrite_in & ~stall_out, injecting a bubble into MEM/WB.
REQ-022 rd_out SHALL hold its last value across non-memory instructions.

Reset
REQ-023 On reset, the block SHALL set: FSM=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, rd_out=0, bus_err=0.
REQ-024 Reset during WAIT SHALL abandon the access, with dmem_req=0 after that edge; a late ack SHALL be ignored.

Configuration
REQ-025 With MEM_ACCESS_ALIGN_CHECK_EN defined, an access with alu_out_in[1:0]!=0 in IDLE SHALL NOT issue dmem_req, SHALL go directly to DONE, SHALL pulse bus_err, and SHALL set rd_out=0 for loads (stall_out=1 for that one IDLE cycle).
REQ-026 Without MEM_ACCESS_ALIGN_CHECK_EN, dmem_addr[1:0] SHALL be forced to 0 and no check SHALL be made.

Structure
REQ-027 The FSM state typedef and the MAX_WAIT default SHALL reside in shared package cpu_pkg.
REQ-028 The wait counter SHALL be a sub-module mem_wait_timer (clear, enable, limit, expired).
REQ-029 The block SHALL be a single clock domain with no latches.

Verification
REQ-030 The bench SHALL cover these scenarios:
- Load, addr 0x100, ack on the 1st WAIT cycle, rdata 0xDEADBEEF -> stall_out high for 2 cycles, rd_out=0xDEADBEEF in DONE, RegWrite_out=0 while stalled.
- Store, addr 0x200, wdata 0x12345678, ack after 4 cycles -> dmem_we=1, addr and wdata stable for all 4 cycles, rd_out unchanged.
- Load with no ack, MAX_WAIT=15 -> bus_err pulse on the 15th WAIT cycle, rd_out=0, stall released next cycle.
- Ack coincident with the timeout cycle -> data captured, bus_err=0.
- Reset asserted in the 3rd WAIT cycle -> dmem_req=0 and stall_out=0 on the next cycle, a later ack ignored.
- Load to 0x102 with the macro defined -> no dmem_req, bus_err=1, rd_out=0; without the macro -> dmem_addr=0x100.
